// File: rtl/apb_pkg.sv
// Shared constants, FSM state encoding and width helper for the APB hub.
package apb_pkg;

    localparam int unsigned APB_ADDR_W  = 9;
    localparam int unsigned APB_DATA_W  = 8;
    localparam int unsigned APB_NUM_SLV = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_decoder.sv
// Combinational completer decode: top address bits -> one-hot select, or decode error.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned NUM_SLV = APB_NUM_SLV
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               dec_err
);

    localparam int unsigned SEL_W = min_width(NUM_SLV);

    logic [SEL_W-1:0] idx;
    logic             unused_low;

    // Only the top SEL_W address bits take part in the decode.
    assign unused_low = ^addr[ADDR_W-SEL_W-1:0];

    // Index compare per completer; an index past the last completer selects nothing.
    always_comb begin
        idx = (NUM_SLV == 1) ? '0 : addr[ADDR_W-1 -: SEL_W];
        sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            sel[i] = (idx == SEL_W'(i));
        end
        dec_err = ~|sel;
    end

endmodule

// File: rtl/apb_hub.sv
// Command-to-APB bridge: one outstanding transfer, decode to NUM_SLV completers,
// per-transfer wait timeout, single-cycle response pulse.
module apb_hub
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned NUM_SLV = APB_NUM_SLV,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int unsigned     CNT_W     = min_width(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    apb_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_SLV-1:0]   dec_sel;
    logic                 dec_err;
    logic                 sel_ready;
    logic                 sel_err;
    logic [DATA_W-1:0]    sel_rdata;

    apb_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV)
    ) u_decoder (
        .addr    (cmd_addr),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    // Response mux: only the completer currently selected is observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                sel_ready = sel_ready | pready[i];
                sel_err   = sel_err | pslverr[i];
                sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; bus fields hold unless a command is captured.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        ready_d     = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                cnt_d     = '0;
                ready_d   = 1'b1;
                if (cmd_valid) begin
                    if (dec_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_wdata;
                        psel_d   = dec_sel;
                        ready_d  = 1'b0;
                        state_d  = ST_SETUP;
                    end
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (sel_ready) begin
                    // Completion takes priority over a timeout firing on the same edge.
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                ready_d   = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves IDLE with the ready flop preset.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
        end
    end

    // The ready flop is masked during reset so it reads 0 there, yet a command
    // can still be taken on the very first edge after reset is released.
    assign cmd_ready = ready_q & ~preset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;

endmodule

// File: tb/tb_apb_hub.sv
// Self-checking bench for apb_hub: directed, random, back-to-back, decode error and reset cases.
module tb_apb_hub;

    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 8;
    localparam int unsigned NS  = 2;
    localparam int          TMO = 4;

    typedef struct {
        int         lat;
        int         waits;
        logic       err;
        logic [7:0] rdata;
        logic [20:0] setup_bus;
        logic [20:0] access_bus;
        logic       stable;
        logic [3:0] post;
    } obs_t;

    logic          pclk;
    logic          preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [NS-1:0] psel;
    logic          penable;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0] pready, pslverr;

    logic          c3_cmd_valid, c3_cmd_ready, c3_cmd_write;
    logic [AW-1:0] c3_cmd_addr;
    logic [DW-1:0] c3_cmd_wdata;
    logic          c3_rsp_valid, c3_rsp_err;
    logic [DW-1:0] c3_rsp_rdata;
    logic [AW-1:0] c3_paddr;
    logic          c3_pwrite;
    logic [DW-1:0] c3_pwdata;
    logic [2:0]    c3_psel;
    logic          c3_penable;
    logic [23:0]   c3_prdata;
    logic [2:0]    c3_pready, c3_pslverr;

    int         total = 0;
    int         bad   = 0;
    int         plan_idx = 0;
    int         plan_w = 0;
    logic       plan_err = 1'b0;
    logic [7:0] plan_rdata = 8'h00;

    apb_hub #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_hub #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3), .TIMEOUT(TMO)) dut3 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_write(c3_cmd_write),
        .cmd_addr(c3_cmd_addr), .cmd_wdata(c3_cmd_wdata),
        .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rsp_rdata), .rsp_err(c3_rsp_err),
        .paddr(c3_paddr), .pwrite(c3_pwrite), .pwdata(c3_pwdata), .psel(c3_psel),
        .penable(c3_penable), .prdata(c3_prdata), .pready(c3_pready), .pslverr(c3_pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Completer model: the planned completer answers after plan_w ACCESS cycles,
    // every other slice carries random noise.
    initial begin
        int acc_n;
        acc_n = 0;
        pready = '0; pslverr = '0; prdata = '0;
        forever begin
            @(negedge pclk);
            for (int i = 0; i < NS; i++) begin
                pready[i]        = 1'($urandom);
                pslverr[i]       = 1'($urandom);
                prdata[i*8 +: 8] = 8'($urandom);
            end
            if (psel[plan_idx] && penable) begin
                pready[plan_idx] = (acc_n == plan_w);
                if (acc_n == plan_w) begin
                    pslverr[plan_idx]       = plan_err;
                    prdata[plan_idx*8 +: 8] = plan_rdata;
                end
                acc_n++;
            end else begin
                acc_n = 0;
            end
        end
    end

    function automatic logic [20:0] bus_now();
        return {psel, penable, paddr, pwrite, pwdata};
    endfunction

    // Expected bus picture for a captured command.
    function automatic logic [20:0] model_bus(input logic [8:0] a, input logic wr,
                                              input logic [7:0] wd, input logic en);
        logic [1:0] oh;
        oh = (a[8]) ? 2'b10 : 2'b01;
        return {oh, en, a, wr, wd};
    endfunction

    function automatic int model_lat(input int w);
        return 3 + ((w > TMO) ? TMO : w);
    endfunction

    function automatic logic model_err(input int w, input logic e);
        return (w > TMO) || e;
    endfunction

    function automatic logic [7:0] model_rdata(input logic wr, input int w, input logic e,
                                               input logic [7:0] rd);
        return (!wr && !model_err(w, e)) ? rd : 8'h00;
    endfunction

    // Drive one command and record what the DUT does; sampled 1 time unit after edges.
    task automatic run_transfer(input logic wr, input logic [8:0] a, input logic [7:0] wd,
                                input int w, input logic e, input logic [7:0] rd,
                                output obs_t o);
        int edges;
        o.lat = -1; o.waits = 0; o.err = 1'b0; o.rdata = 8'h00;
        o.setup_bus = '0; o.access_bus = '0; o.stable = 1'b1; o.post = '0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        while (!cmd_ready && o.waits < 20) begin
            @(posedge pclk); #1;
            o.waits++;
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            o.lat = -2;
            return;
        end
        plan_idx = int'(a[8]); plan_w = w; plan_err = e; plan_rdata = rd;
        @(posedge pclk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom);
        cmd_addr = 9'($urandom); cmd_wdata = 8'($urandom);
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            if (edges == 1) o.setup_bus = bus_now();
            else if (edges == 2) o.access_bus = bus_now();
            else if (bus_now() !== o.access_bus) o.stable = 1'b0;
            @(posedge pclk); #1;
            edges++;
        end
        if (rsp_valid) begin
            o.lat = edges; o.err = rsp_err; o.rdata = rsp_rdata;
            o.post = {psel, penable, cmd_ready};
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h105; cmd_wdata = 8'hFF;
        c3_cmd_valid = 1'b0; c3_cmd_write = 1'b0; c3_cmd_addr = '0; c3_cmd_wdata = '0;
        c3_pready = 3'b111; c3_pslverr = 3'b000; c3_prdata = 24'h5E1122;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            total++;
            if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, pwdata, psel, penable} !== '0) begin
                bad++;
                $display("FAIL reset_outputs got=%h exp=0",
                         {cmd_ready, rsp_valid, rsp_err, rsp_rdata, paddr, pwrite, pwdata, psel, penable});
            end
        end
        total++;
        if ({c3_cmd_ready, c3_rsp_valid, c3_psel, c3_penable, c3_paddr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs3 got=%h exp=0", {c3_cmd_ready, c3_rsp_valid, c3_psel, c3_penable, c3_paddr});
        end
        cmd_valid = 1'b0;
        preset = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_directed();
        logic       t_wr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] t_a  [7] = '{9'h105, 9'h020, 9'h010, 9'h0F0, 9'h1F0, 9'h040, 9'h1AA};
        logic [7:0] t_wd [7] = '{8'hA5, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h12};
        int         t_w  [7] = '{0, 2, 100, 4, 3, 0, 1};
        logic       t_e  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] t_rd [7] = '{8'h00, 8'h3C, 8'h99, 8'h5A, 8'hC3, 8'h77, 8'h00};
        obs_t o;
        int xl; logic xe; logic [7:0] xr;
        for (int i = 0; i < 7; i++) begin
            run_transfer(t_wr[i], t_a[i], t_wd[i], t_w[i], t_e[i], t_rd[i], o);
            xl = model_lat(t_w[i]);
            xe = model_err(t_w[i], t_e[i]);
            xr = model_rdata(t_wr[i], t_w[i], t_e[i], t_rd[i]);
            total++;
            if (o.lat !== xl) begin
                bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, o.lat, xl);
            end
            total++;
            if ({o.err, o.rdata} !== {xe, xr}) begin
                bad++; $display("FAIL dir%0d_rsp got=%b/%h exp=%b/%h", i, o.err, o.rdata, xe, xr);
            end
            total++;
            if (o.setup_bus !== model_bus(t_a[i], t_wr[i], t_wd[i], 1'b0)) begin
                bad++; $display("FAIL dir%0d_setup_bus got=%h exp=%h", i, o.setup_bus,
                                model_bus(t_a[i], t_wr[i], t_wd[i], 1'b0));
            end
            total++;
            if (o.access_bus !== model_bus(t_a[i], t_wr[i], t_wd[i], 1'b1) || !o.stable) begin
                bad++; $display("FAIL dir%0d_access_bus got=%h stable=%b exp=%h", i, o.access_bus,
                                o.stable, model_bus(t_a[i], t_wr[i], t_wd[i], 1'b1));
            end
            total++;
            if (o.post !== 4'b0001) begin
                bad++; $display("FAIL dir%0d_post got=%b exp=0001", i, o.post);
            end
            @(posedge pclk); #1;
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++; $display("FAIL dir%0d_pulse_width got=%b exp=0", i, rsp_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   t_w [3] = '{0, 1, 0};
        obs_t o;
        logic [8:0] a; logic [7:0] wd, rd; logic wr;
        for (int i = 0; i < 3; i++) begin
            a = 9'($urandom); wd = 8'($urandom); rd = 8'($urandom); wr = (i == 1);
            run_transfer(wr, a, wd, t_w[i], 1'b0, rd, o);
            if (i > 0) begin
                total++;
                if (o.waits !== 0) begin
                    bad++; $display("FAIL b2b%0d_accept_wait got=%0d exp=0", i, o.waits);
                end
            end
            total++;
            if (o.lat !== model_lat(t_w[i])) begin
                bad++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, o.lat, model_lat(t_w[i]));
            end
            total++;
            if ({o.err, o.rdata} !== {1'b0, model_rdata(wr, t_w[i], 1'b0, rd)}) begin
                bad++; $display("FAIL b2b%0d_rsp got=%b/%h exp=0/%h", i, o.err, o.rdata,
                                model_rdata(wr, t_w[i], 1'b0, rd));
            end
        end
        @(posedge pclk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_pulse_width got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic wr, e; logic [8:0] a; logic [7:0] wd, rd; int w;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom); a = 9'($urandom); wd = 8'($urandom); rd = 8'($urandom);
            w = int'($urandom_range(0, 6)); e = ($urandom_range(0, 3) == 0);
            run_transfer(wr, a, wd, w, e, rd, o);
            total++;
            if (o.lat !== model_lat(w)) begin
                bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d w=%0d", i, o.lat, model_lat(w), w);
            end
            total++;
            if ({o.err, o.rdata} !== {model_err(w, e), model_rdata(wr, w, e, rd)}) begin
                bad++; $display("FAIL rnd%0d_rsp got=%b/%h exp=%b/%h", i, o.err, o.rdata,
                                model_err(w, e), model_rdata(wr, w, e, rd));
            end
            total++;
            if (o.setup_bus !== model_bus(a, wr, wd, 1'b0) || o.access_bus !== model_bus(a, wr, wd, 1'b1)
                || !o.stable) begin
                bad++; $display("FAIL rnd%0d_bus got=%h/%h stable=%b exp=%h/%h", i, o.setup_bus,
                                o.access_bus, o.stable, model_bus(a, wr, wd, 1'b0), model_bus(a, wr, wd, 1'b1));
            end
            total++;
            if (o.post !== 4'b0001) begin
                bad++; $display("FAIL rnd%0d_post got=%b exp=0001", i, o.post);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge pclk); #1;
            end
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_decode_err();
        c3_cmd_valid = 1'b1; c3_cmd_write = 1'b1; c3_cmd_addr = 9'h180; c3_cmd_wdata = 8'h44;
        total++;
        if (c3_cmd_ready !== 1'b1) begin
            bad++; $display("FAIL dec_ready got=%b exp=1", c3_cmd_ready);
        end
        @(posedge pclk); #1;
        c3_cmd_valid = 1'b0;
        total++;
        if ({c3_rsp_valid, c3_rsp_err, c3_rsp_rdata, c3_psel, c3_penable, c3_cmd_ready}
            !== {1'b1, 1'b1, 8'h00, 3'b000, 1'b0, 1'b1}) begin
            bad++; $display("FAIL dec_err_rsp got=%b%b_%h_%b%b%b exp=11_00_00001", c3_rsp_valid, c3_rsp_err,
                            c3_rsp_rdata, c3_psel, c3_penable, c3_cmd_ready);
        end
        @(posedge pclk); #1;
        total++;
        if ({c3_rsp_valid, c3_psel} !== 4'b0000) begin
            bad++; $display("FAIL dec_err_after got=%b exp=0000", {c3_rsp_valid, c3_psel});
        end
        c3_cmd_valid = 1'b1; c3_cmd_write = 1'b0; c3_cmd_addr = 9'h100;
        @(posedge pclk); #1;
        c3_cmd_valid = 1'b0;
        total++;
        if ({c3_psel, c3_penable} !== 4'b1000) begin
            bad++; $display("FAIL dec_c2_setup got=%b exp=1000", {c3_psel, c3_penable});
        end
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        total++;
        if ({c3_rsp_valid, c3_rsp_err, c3_rsp_rdata} !== {1'b1, 1'b0, 8'h5E}) begin
            bad++; $display("FAIL dec_c2_read got=%b%b_%h exp=10_5e", c3_rsp_valid, c3_rsp_err, c3_rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        plan_idx = 0; plan_w = 100; plan_err = 1'b0; plan_rdata = 8'hAB;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h030; cmd_wdata = 8'h00;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        total++;
        if ({psel, penable} !== 3'b011) begin
            bad++; $display("FAIL rst_pre_access got=%b exp=011", {psel, penable});
        end
        #2;
        preset = 1'b1;
        #1;
        total++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 5'b00000) begin
            bad++; $display("FAIL rst_async_clear got=%b exp=00000", {psel, penable, rsp_valid, cmd_ready});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            total++;
            if ({psel, penable, rsp_valid} !== 4'b0000) begin
                bad++; $display("FAIL rst_hold%0d got=%b exp=0000", i, {psel, penable, rsp_valid});
            end
        end
        preset = 1'b0;
        #1;
        run_transfer(1'b1, 9'h1A0, 8'h3E, 1, 1'b0, 8'h00, o);
        total++;
        if (o.waits !== 0 || o.lat !== model_lat(1)) begin
            bad++; $display("FAIL rst_first_cmd got=waits%0d/lat%0d exp=waits0/lat%0d", o.waits, o.lat, model_lat(1));
        end
        total++;
        if ({o.err, o.rdata} !== 9'h000 || o.setup_bus !== model_bus(9'h1A0, 1'b1, 8'h3E, 1'b0)) begin
            bad++; $display("FAIL rst_first_rsp got=%b/%h bus=%h exp=0/00 bus=%h", o.err, o.rdata, o.setup_bus,
                            model_bus(9'h1A0, 1'b1, 8'h3E, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_decode_err();
        test_reset_mid_access();
        @(posedge pclk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
